// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte producers,
// each buffered by its own DEPTH-entry FIFO.
module uart_tx_arbiter #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_byte,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_byte,
  output logic             req1_ready,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] tx_byte,
  output logic             tx_enable,
  input  logic             tx_busy,
  output logic             grant,
  output logic             active,
  output logic [1:0]       overflow,
  output logic             timeout
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [AW-1:0]    wr_ptr [2];
  logic [AW-1:0]    rd_ptr [2];
  logic [CW-1:0]    count  [2];
  logic [WIDTH-1:0] din    [2];
  logic [1:0]       avail_q;
  logic [1:0]       valid;
  logic [1:0]       full;
  logic [1:0]       avail;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic             issue;
  logic             sel;
  logic [TW-1:0]    tmo_cnt;
  logic             tmo_event;

  always_comb begin
    valid  = {req1_valid, req0_valid};
    din[0] = req0_byte;
    din[1] = req1_byte;
    full   = '0;
    avail  = '0;
    push   = '0;
    for (int unsigned c = 0; c < 2; c++) begin
      full[c]  = (count[c] == CW'(DEPTH));
      // availability is seen through a register, giving the two-edge issue latency
      avail[c] = avail_q[c] && (count[c] != '0);
      push[c]  = valid[c] && !full[c];
    end
    issue = (state == IDLE) && !tx_busy && (|avail);
    sel   = (&avail) ? ~grant : ~avail[0];
    pop   = '0;
    if (issue) pop[sel] = 1'b1;
    tmo_event = (state == WAIT_BUSY) && !tx_busy &&
                (tmo_cnt == TW'(BUSY_TIMEOUT - 1));
  end

  assign req0_ready = ~full[0];
  assign req1_ready = ~full[1];
  assign active     = (state != IDLE);

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < 2; c++)
      if (push[c]) mem[c][wr_ptr[c]] <= din[c];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < 2; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      avail_q  <= '0;
      overflow <= '0;
    end else begin
      for (int unsigned c = 0; c < 2; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + AW'(1);
        case ({push[c], pop[c]})
          2'b10:   count[c] <= count[c] + CW'(1);
          2'b01:   count[c] <= count[c] - CW'(1);
          default: count[c] <= count[c];
        endcase
        avail_q[c]  <= (count[c] != '0);
        overflow[c] <= (overflow[c] & ~clr_flags) | (valid[c] & full[c]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tx_byte   <= '0;
      tx_enable <= 1'b0;
      grant     <= 1'b1;
      tmo_cnt   <= '0;
      timeout   <= 1'b0;
    end else begin
      tx_enable <= 1'b0;
      timeout   <= (timeout & ~clr_flags) | tmo_event;
      case (state)
        IDLE: begin
          if (issue) begin
            tx_byte   <= mem[sel][rd_ptr[sel]];
            grant     <= sel;
            tx_enable <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          tmo_cnt <= '0;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy)        state   <= WAIT_DONE;
          else if (tmo_event) state   <= IDLE;
          else                tmo_cnt <= tmo_cnt + TW'(1);
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed pushes queue expected frames,
// a monitor checks every tx_enable pulse against the queue.
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [7:0] b;
    logic       g;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_byte = '0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_byte = '0;
  logic       req1_ready;
  logic       clr_flags = 1'b0;
  logic [7:0] tx_byte;
  logic       tx_enable;
  logic       tx_busy;
  logic       grant;
  logic       active;
  logic [1:0] overflow;
  logic       timeout;

  logic       force_high = 1'b0;
  logic       model_busy = 1'b0;
  logic       auto_en = 1'b1;
  int         busy_len = 10;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   en_count = 0;

  always #5 clk = ~clk;

  always_comb tx_busy = force_high | model_busy;

  uart_tx_arbiter #(.WIDTH(8), .DEPTH(4), .BUSY_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_byte(req0_byte), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_byte(req1_byte), .req1_ready(req1_ready),
    .clr_flags(clr_flags), .tx_byte(tx_byte), .tx_enable(tx_enable),
    .tx_busy(tx_busy), .grant(grant), .active(active),
    .overflow(overflow), .timeout(timeout)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic bound_ok(input string name, input int k, input int lim);
    n_total++;
    if (k < lim) n_pass++;
    else $display("FAIL %s: waited %0d cycles, limit %0d", name, k, lim);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [7:0] b0, input logic v1, input logic [7:0] b1);
    req0_valid = v0; req0_byte = b0;
    req1_valid = v1; req1_byte = b1;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic expect_tx(input logic [7:0] b, input logic g);
    exp_t e;
    e.b = b;
    e.g = g;
    q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (k < 400 && (q.size() != 0 || active || tx_busy)) begin
      tick();
      k++;
    end
    bound_ok(name, k, 400);
  endtask

  // monitor: every transmitter start must match the next expected frame
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && tx_enable) begin
      en_count++;
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_tx_enable: got tx_byte=%h expected no frame at %0t", tx_byte, $time);
      end else begin
        e = q.pop_front();
        check("tx_byte", tx_byte, e.b);
        check("tx_grant", {7'b0, grant}, {7'b0, e.g});
      end
    end
  end

  // transmitter model: busy rises one cycle after the start pulse
  initial begin
    forever begin
      @(negedge clk);
      if (auto_en && reset && tx_enable) begin
        @(negedge clk);
        model_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        model_busy = 1'b0;
      end
    end
  end

  initial begin
    int k;
    int en_snap;

    // reset values
    tick();
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_tx_enable", {7'b0, tx_enable}, 8'h00);
    check("rst_grant", {7'b0, grant}, 8'h01);
    check("rst_active", {7'b0, active}, 8'h00);
    check("rst_overflow", {6'b0, overflow}, 8'h00);
    check("rst_timeout", {7'b0, timeout}, 8'h00);
    check("rst_ready", {6'b0, req1_ready, req0_ready}, 8'h03);
    reset = 1'b1;
    tick();

    // single byte: latency and active drop
    expect_tx(8'h41, 1'b0);
    drive(1'b1, 8'h41, 1'b0, 8'h00);
    tick();
    check("lat_edge1", {7'b0, tx_enable}, 8'h00);
    tick();
    check("lat_edge2", {7'b0, tx_enable}, 8'h01);
    k = 0;
    while (!model_busy && k < 50) begin tick(); k++; end
    while (model_busy && k < 50) begin tick(); k++; end
    bound_ok("busy_frame", k, 50);
    check("active_wait_done", {7'b0, active}, 8'h01);
    tick();
    check("active_after_done", {7'b0, active}, 8'h00);

    // round robin over both channels
    do_reset();
    expect_tx(8'hA0, 1'b0);
    expect_tx(8'hB0, 1'b1);
    expect_tx(8'hA1, 1'b0);
    expect_tx(8'hB1, 1'b1);
    drive(1'b1, 8'hA0, 1'b1, 8'hB0);
    drive(1'b1, 8'hA1, 1'b1, 8'hB1);
    wait_drain("rr_drain");

    // overflow on ch1 while transmitter owned externally
    do_reset();
    force_high = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_tx(8'hC0 + 8'(i), 1'b1);
      drive(1'b0, 8'h00, 1'b1, 8'hC0 + 8'(i));
    end
    check("full_ready", {7'b0, req1_ready}, 8'h00);
    check("full_no_ovf", {6'b0, overflow}, 8'h00);
    drive(1'b0, 8'h00, 1'b1, 8'hC4);
    check("ovf_set", {6'b0, overflow}, 8'h02);
    check("hold_idle", {7'b0, active}, 8'h00);
    force_high = 1'b0;
    wait_drain("ovf_drain");
    check("ovf_sticky", {6'b0, overflow}, 8'h02);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("ovf_clear", {6'b0, overflow}, 8'h00);
    check("ready_after_drain", {7'b0, req1_ready}, 8'h01);

    // busy never rises: timeout
    do_reset();
    auto_en = 1'b0;
    expect_tx(8'h55, 1'b0);
    drive(1'b1, 8'h55, 1'b0, 8'h00);
    k = 0;
    while (!tx_enable && k < 20) begin tick(); k++; end
    bound_ok("tmo_enable", k, 20);
    repeat (8) tick();
    check("tmo_not_yet", {7'b0, timeout}, 8'h00);
    check("tmo_still_active", {7'b0, active}, 8'h01);
    tick();
    check("tmo_set", {7'b0, timeout}, 8'h01);
    check("tmo_idle", {7'b0, active}, 8'h00);
    auto_en = 1'b1;
    expect_tx(8'h66, 1'b0);
    drive(1'b1, 8'h66, 1'b0, 8'h00);
    wait_drain("tmo_next_drain");
    check("tmo_sticky", {7'b0, timeout}, 8'h01);

    // reset during WAIT_DONE with bytes queued
    do_reset();
    expect_tx(8'hD0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hD0 + 8'(i), 1'b0, 8'h00);
    k = 0;
    while (!model_busy && k < 30) begin tick(); k++; end
    bound_ok("wd_reach", k, 30);
    tick();
    tick();
    check("wd_active", {7'b0, active}, 8'h01);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_tx_byte", tx_byte, 8'h00);
    check("mid_rst_enable", {7'b0, tx_enable}, 8'h00);
    check("mid_rst_grant", {7'b0, grant}, 8'h01);
    check("mid_rst_active", {7'b0, active}, 8'h00);
    check("mid_rst_ready", {6'b0, req1_ready, req0_ready}, 8'h03);
    tick();
    reset = 1'b1;
    en_snap = en_count;
    repeat (20) tick();
    check("no_tx_after_rst", 8'(en_count - en_snap), 8'h00);
    expect_tx(8'h77, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 8'h00);
    wait_drain("rst_next_drain");

    // push and pop on ch0 in the same cycle at occupancy 2
    do_reset();
    force_high = 1'b1;
    for (int i = 0; i < 5; i++) expect_tx(8'hE0 + 8'(i), 1'b0);
    drive(1'b1, 8'hE0, 1'b0, 8'h00);
    drive(1'b1, 8'hE1, 1'b0, 8'h00);
    force_high = 1'b0;
    drive(1'b1, 8'hE2, 1'b0, 8'h00);
    check("pp_issued", {7'b0, active}, 8'h01);
    drive(1'b1, 8'hE3, 1'b0, 8'h00);
    check("pp_occ3_ready", {7'b0, req0_ready}, 8'h01);
    drive(1'b1, 8'hE4, 1'b0, 8'h00);
    check("pp_occ4_full", {7'b0, req0_ready}, 8'h00);
    wait_drain("pp_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
